host_cmd_bridge: RTL and testbench
==================================

Name: host_cmd_bridge

Overview:
- Host-facing front end of the matrix processing unit; sits directly upstream of the control FSM.
- Accepts 8-bit instructions and byte payloads from the host over valid/ready channels.
- Pre-buffers the 64-byte LOAD payload so it can be streamed to the FSM one byte per cycle without stalls.
- Captures the 64 UNLOAD bytes one per cycle and drains them back to the host under backpressure.

Parameters:
- NUM_BITS, 512, BRAM word width in bits.
- NUM_BYTES, 64, bytes per word (NUM_BITS/8); byte k maps to bits [8k+7:8k]. Index counters are log2(NUM_BYTES) bits wide.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host instruction valid
- cmd_ready  out  1  bridge can accept an instruction
- cmd_data  in  8  instruction: [7:6] DD, [5:4] AA, [3:0] opcode
- ld_valid  in  1  host load byte valid
- ld_ready  out  1  bridge can accept a load byte
- ld_data  in  8  load byte
- ul_valid  out  1  unload byte valid to host
- ul_ready  in  1  host accepts unload byte
- ul_data  out  8  unload byte
- host_instruction  out  8  instruction presented to the control FSM
- busy  in  1  control FSM busy
- host_byte  out  8  load byte presented to the BRAM write path
- unload_byte  in  8  byte from the host output mux at the FSM's current offset
- bridge_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; byte counter = 0.
  - All outputs are 0: cmd_ready, ld_ready, ul_valid, ul_data, host_byte, host_instruction (8'h00, which decodes as NOP), bridge_busy.
  - Reset mid-operation discards the buffer contents and any pending command. Host traffic that is in flight is lost.
- Opcode decode on cmd_data[3:0]:
  - 0100 LOAD
  - 0110 UNLOAD
  - 0101 COPY
  - 0111 CLEAR
  - 1100, 1101, 1110, 1111 ALU
  - 00xx NOP
- States and transitions:
  - IDLE: cmd_ready=1. On a cmd_valid&cmd_ready handshake, latch cmd_data and branch: LOAD -> FILL; UNLOAD, COPY, CLEAR, ALU -> ISSUE; NOP -> stay in IDLE (command dropped, nothing issued).
  - FILL: ld_ready=1. Each ld handshake writes buffer[cnt] and increments cnt. The handshake at cnt=NUM_BYTES-1 goes to ISSUE with cnt reset to 0. cmd_valid is ignored in this state.
  - ISSUE: host_instruction = latched command. Leave on the first rising edge at which busy is sampled 0; that edge is the FSM capture edge, called I. LOAD/UNLOAD -> STREAM; other commands -> WAIT. host_instruction returns to 8'h00 on every cycle outside ISSUE.
  - STREAM: lasts exactly NUM_BYTES cycles, I+1 through I+NUM_BYTES.
    - LOAD: host_byte = buffer[k] during cycle I+1+k, with no gaps.
    - UNLOAD: buffer[k] captures unload_byte at the end of cycle I+1+k.
    - cnt wraps to 0 at the end. LOAD -> WAIT; UNLOAD -> DRAIN.
    - busy is not checked during STREAM; the FSM is committed to NUM_BYTES cycles.
  - WAIT: occupies at least 1 cycle. Return to IDLE on the first edge where busy=0.
  - DRAIN:
    - ul_valid=1 and ul_data=buffer[cnt].
    - Each ul handshake increments cnt; the handshake at cnt=NUM_BYTES-1 goes to IDLE.
    - ul_valid is held while ul_ready=0, with ul_data stable.
- host_byte holds its last value outside STREAM-LOAD.
- Simultaneous events: only one channel is ready in any state, so no arbitration is needed. bridge_busy = (state != IDLE).
- Throughput: the next command is accepted no earlier than the cycle after the return to IDLE.

Decomposition:
- Shared package mpu_pkg holds:
  - opcode constants (LOAD, UNLOAD, COPY, CLEAR, ADD, SHIFT, SUB, MULT, NOP), common with the control FSM;
  - BRAM select encodings B0–B3;
  - the bridge state encoding.
- One sub-module, byte_buffer: NUM_BYTES x 8 register file with one write port and one asynchronous read port, indexed by cnt, no reset on storage.

Test Plan:
- LOAD: send cmd 8'h04, then bytes 0x00..0x3F with ld_valid held. Required response:
  - cmd_ready drops; host_instruction=8'h04 until busy is sampled 0.
  - host_byte = 0x00..0x3F on consecutive cycles I+1..I+64.
  - Returns to IDLE once the FSM drops busy.
- UNLOAD with backpressure: send cmd 8'h16 while a model drives unload_byte = 0xA0+k in cycle I+1+k. Toggle ul_ready 1,0,1,0. Required: ul_data = 0xA0..0xDF in order, each held stable while ul_ready=0, and exactly 64 handshakes.
- Single-cycle ops: send cmd 8'hBC (ADD, DD=2, AA=3) and then 8'h47 (CLEAR). Required for each: host_instruction is asserted only in ISSUE, the bridge passes through WAIT, and bridge_busy falls after busy falls.
- NOP: send cmd 8'h01. Required: handshake completes, host_instruction stays 8'h00, bridge_busy stays 0.
- Reset mid-FILL: assert reset after 10 load bytes. Required: state is IDLE, all outputs 0. A subsequent full LOAD of 0x40..0x7F streams only the new bytes.
- Issue stall: hold busy=1 for 5 cycles while in ISSUE. Required: host_instruction is held for those 5 cycles, and STREAM starts exactly 1 cycle after the first edge at which busy is sampled 0.

Source files
------------

// File: rtl/mpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpu_pkg
// Description : Opcodes, BRAM selects and bridge state encoding shared by the
//               host command bridge and the control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package mpu_pkg;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b0100;
    localparam logic [3:0] OP_COPY   = 4'b0101;
    localparam logic [3:0] OP_UNLOAD = 4'b0110;
    localparam logic [3:0] OP_CLEAR  = 4'b0111;
    localparam logic [3:0] OP_ADD    = 4'b1100;
    localparam logic [3:0] OP_SHIFT  = 4'b1101;
    localparam logic [3:0] OP_SUB    = 4'b1110;
    localparam logic [3:0] OP_MULT   = 4'b1111;

    localparam logic [1:0] B0 = 2'b00;
    localparam logic [1:0] B1 = 2'b01;
    localparam logic [1:0] B2 = 2'b10;
    localparam logic [1:0] B3 = 2'b11;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_FILL   = 3'd1;
    localparam logic [STATE_W-1:0] ST_ISSUE  = 3'd2;
    localparam logic [STATE_W-1:0] ST_STREAM = 3'd3;
    localparam logic [STATE_W-1:0] ST_WAIT   = 3'd4;
    localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd5;

    typedef struct packed {
        logic [1:0] dd;
        logic [1:0] aa;
        logic [3:0] op;
    } instr_t;

    // Where an accepted instruction goes from IDLE; unknown opcodes are dropped like NOP.
    function automatic logic [STATE_W-1:0] idle_branch(input logic [3:0] op);
        logic [STATE_W-1:0] nxt;
        nxt = ST_IDLE;
        if (op == OP_LOAD) begin
            nxt = ST_FILL;
        end else if ((op[3:2] == 2'b11) || (op == OP_UNLOAD) ||
                     (op == OP_COPY) || (op == OP_CLEAR)) begin
            nxt = ST_ISSUE;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_buffer.sv
`default_nettype none
// ============================================================================
// Module      : byte_buffer
// Description : DEPTH x 8 register file, one write port, asynchronous read at
//               the same index.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/host_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : host_cmd_bridge
// Description : Host-side instruction/payload front end ahead of the control
//               FSM; buffers LOAD payloads and drains UNLOAD results.
// Revision    : 1.0 - initial release
// ============================================================================
module host_cmd_bridge
    import mpu_pkg::*;
#(
    parameter int NUM_BITS  = 512,
    parameter int NUM_BYTES = NUM_BITS / 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [7:0] ld_data,
    output logic       ul_valid,
    input  logic       ul_ready,
    output logic [7:0] ul_data,
    output logic [7:0] host_instruction,
    input  logic       busy,
    output logic [7:0] host_byte,
    input  logic [7:0] unload_byte,
    output logic       bridge_busy
);

    localparam int CNT_W = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_BYTES - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    instr_t             r_cmd;
    instr_t             w_next_cmd;
    instr_t             r_host_instruction;
    logic               r_cmd_ready;
    logic               r_ld_ready;
    logic               r_ul_valid;
    logic               r_bridge_busy;
    logic [7:0]         r_host_byte;

    logic       w_cmd_fire;
    logic       w_ld_fire;
    logic       w_ul_fire;
    logic       w_is_load;
    logic       w_streams;
    logic       w_last;
    logic       w_stream_load;
    logic       w_buf_we;
    logic [7:0] w_buf_wdata;
    logic [7:0] w_buf_rdata;

    assign w_cmd_fire    = cmd_valid & r_cmd_ready;
    assign w_ld_fire     = ld_valid & r_ld_ready;
    assign w_ul_fire     = r_ul_valid & ul_ready;
    assign w_is_load     = (r_cmd.op == OP_LOAD);
    assign w_streams     = w_is_load | (r_cmd.op == OP_UNLOAD);
    assign w_last        = (r_cnt == C_LAST);
    assign w_stream_load = (r_state == ST_STREAM) & w_is_load;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_cmd   = r_cmd;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    w_next_cmd   = cmd_data;
                    w_next_state = idle_branch(cmd_data[3:0]);
                end
            end
            ST_FILL: begin
                if (w_ld_fire) begin
                    w_next_cnt = r_cnt + 1'b1;
                    if (w_last) begin
                        w_next_cnt   = '0;
                        w_next_state = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!busy) begin
                    w_next_state = w_streams ? ST_STREAM : ST_WAIT;
                end
            end
            // The FSM is committed once it captures; busy is not consulted here.
            ST_STREAM: begin
                w_next_cnt = r_cnt + 1'b1;
                if (w_last) begin
                    w_next_cnt   = '0;
                    w_next_state = w_is_load ? ST_WAIT : ST_DRAIN;
                end
            end
            ST_WAIT: begin
                if (!busy) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_ul_fire) begin
                    w_next_cnt = r_cnt + 1'b1;
                    if (w_last) begin
                        w_next_cnt   = '0;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Handshake/status outputs are registered from the next state so they read 0 under reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_cnt              <= '0;
            r_cmd              <= '0;
            r_host_instruction <= '0;
            r_cmd_ready        <= 1'b0;
            r_ld_ready         <= 1'b0;
            r_ul_valid         <= 1'b0;
            r_bridge_busy      <= 1'b0;
            r_host_byte        <= 8'h00;
        end else begin
            r_state            <= w_next_state;
            r_cnt              <= w_next_cnt;
            r_cmd              <= w_next_cmd;
            r_host_instruction <= (w_next_state == ST_ISSUE) ? w_next_cmd : '0;
            r_cmd_ready        <= (w_next_state == ST_IDLE);
            r_ld_ready         <= (w_next_state == ST_FILL);
            r_ul_valid         <= (w_next_state == ST_DRAIN);
            r_bridge_busy      <= (w_next_state != ST_IDLE);
            if (w_stream_load) begin
                r_host_byte <= w_buf_rdata;
            end
        end
    end

    assign w_buf_we    = w_ld_fire | ((r_state == ST_STREAM) & ~w_is_load);
    assign w_buf_wdata = (r_state == ST_FILL) ? ld_data : unload_byte;

    byte_buffer #(
        .DEPTH  (NUM_BYTES),
        .ADDR_W (CNT_W)
    ) u_byte_buffer (
        .clk   (clk),
        .we    (w_buf_we),
        .addr  (r_cnt),
        .wdata (w_buf_wdata),
        .rdata (w_buf_rdata)
    );

    assign cmd_ready        = r_cmd_ready;
    assign ld_ready         = r_ld_ready;
    assign ul_valid         = r_ul_valid;
    assign ul_data          = r_ul_valid ? w_buf_rdata : 8'h00;
    assign host_instruction = r_host_instruction;
    assign host_byte        = w_stream_load ? w_buf_rdata : r_host_byte;
    assign bridge_busy      = r_bridge_busy;

endmodule
`default_nettype wire

// File: tb/tb_host_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_cmd_bridge
// Description : Self-checking bench for host_cmd_bridge with an FSM-side model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_cmd_bridge;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_data;
    logic       ld_valid, ld_ready;
    logic [7:0] ld_data;
    logic       ul_valid, ul_ready;
    logic [7:0] ul_data;
    logic [7:0] host_instruction;
    logic       busy;
    logic [7:0] host_byte;
    logic [7:0] unload_byte;
    logic       bridge_busy;

    always #5 clk = ~clk;

    host_cmd_bridge #(.NUM_BITS(512)) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_data         (cmd_data),
        .ld_valid         (ld_valid),
        .ld_ready         (ld_ready),
        .ld_data          (ld_data),
        .ul_valid         (ul_valid),
        .ul_ready         (ul_ready),
        .ul_data          (ul_data),
        .host_instruction (host_instruction),
        .busy             (busy),
        .host_byte        (host_byte),
        .unload_byte      (unload_byte),
        .bridge_busy      (bridge_busy)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] q_load[$];
    logic [7:0] q_ul[$];
    bit         mon_load = 1'b0;
    bit         exit_issue = 1'b0;
    int         stream_k = -1;
    int         ul_count = 0;
    bit         hold_pending = 1'b0;
    logic [7:0] held = 8'h00;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] exp_instr;
        logic       exp_busy;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or scoreboard empty", name);
    endtask

    // FSM-side model: capture edge is an edge where a streaming op sits in ISSUE with busy low.
    always @(posedge clk) begin
        #1;
        if (stream_k >= 0) stream_k = (stream_k == 63) ? -1 : stream_k + 1;
        if (exit_issue) stream_k = 0;
    end

    assign unload_byte = (stream_k >= 0) ? 8'(8'hA0 + stream_k) : 8'h5A;

    always @(negedge clk) begin
        exit_issue = !reset && !busy &&
                     ((host_instruction == 8'h04) || (host_instruction[3:0] == 4'h6));
        if (stream_k >= 0 && mon_load) begin
            if (q_load.size() == 0) fail("host_byte_extra");
            else check("host_byte", host_byte, q_load.pop_front());
        end
        if (ul_valid) begin
            if (hold_pending) check("ul_data_stable", ul_data, held);
            if (ul_ready) begin
                ul_count++;
                if (q_ul.size() == 0) fail("ul_data_extra");
                else check("ul_data", ul_data, q_ul.pop_front());
                hold_pending = 1'b0;
            end else begin
                held = ul_data;
                hold_pending = 1'b1;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) fail("cmd_handshake");
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    task automatic send_loads(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            ld_valid = 1'b1;
            ld_data  = 8'(base + i);
            @(negedge clk);
            while (!ld_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!ld_ready) begin
                fail("ld_handshake");
                break;
            end
            q_load.push_back(8'(base + i));
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (bridge_busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(name, bridge_busy, 1'b0);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
        check({tag, "_ld_ready"}, ld_ready, 1'b0);
        check({tag, "_ul_valid"}, ul_valid, 1'b0);
        check({tag, "_ul_data"}, ul_data, 8'h00);
        check({tag, "_host_byte"}, host_byte, 8'h00);
        check({tag, "_host_instr"}, host_instruction, 8'h00);
        check({tag, "_bridge_busy"}, bridge_busy, 1'b0);
    endtask

    initial begin
        int t;
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; ld_valid = 1'b0;
        ld_data = 8'h00; ul_ready = 1'b0; busy = 1'b0;
        vecs[0] = '{8'hBC, 8'hBC, 1'b1};
        vecs[1] = '{8'h47, 8'h47, 1'b1};
        vecs[2] = '{8'h01, 8'h00, 1'b0};
        vecs[3] = '{8'h35, 8'h35, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1};
        vecs[5] = '{8'h03, 8'h00, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1'b1);
        tick();

        // Single-cycle ops and NOPs: one stall cycle in ISSUE, one busy cycle in WAIT.
        for (int v = 0; v < 6; v++) begin
            busy = 1'b1;
            send_cmd(vecs[v].cmd);
            @(negedge clk);
            check("issue_instr", host_instruction, vecs[v].exp_instr);
            check("issue_bbusy", bridge_busy, vecs[v].exp_busy);
            tick(); busy = 1'b0;
            @(negedge clk);
            check("stall_instr", host_instruction, vecs[v].exp_instr);
            tick(); busy = 1'b1;
            @(negedge clk);
            check("wait_instr", host_instruction, 8'h00);
            check("wait_bbusy", bridge_busy, vecs[v].exp_busy);
            tick(); busy = 1'b0;
            @(negedge clk);
            check("wait_after_busy_fall", bridge_busy, vecs[v].exp_busy);
            tick();
            @(negedge clk);
            check("back_idle_bbusy", bridge_busy, 1'b0);
            check("back_idle_ready", cmd_ready, 1'b1);
            tick();
        end

        // LOAD with a 5-cycle issue stall.
        mon_load = 1'b1;
        busy = 1'b1;
        send_cmd(8'h04);
        @(negedge clk);
        check("load_cmd_ready", cmd_ready, 1'b0);
        check("fill_instr", host_instruction, 8'h00);
        tick();
        send_loads(0, 64);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("load_stall_instr", host_instruction, 8'h04);
            check("load_stall_bbusy", bridge_busy, 1'b1);
            tick();
        end
        busy = 1'b0;
        @(negedge clk);
        check("load_release_instr", host_instruction, 8'h04);
        tick();
        busy = 1'b1;
        @(negedge clk);
        check("stream_instr", host_instruction, 8'h00);
        t = 0;
        while (q_load.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("load_stream_left", q_load.size(), 0);
        @(negedge clk);
        check("host_byte_hold", host_byte, 8'h3F);
        check("load_wait_bbusy", bridge_busy, 1'b1);
        tick();
        busy = 1'b0;
        wait_idle("load_idle");
        mon_load = 1'b0;

        // UNLOAD with ul_ready toggling every cycle.
        ul_count = 0;
        for (int k = 0; k < 64; k++) q_ul.push_back(8'(8'hA0 + k));
        send_cmd(8'h16);
        ul_ready = 1'b1;
        t = 0;
        while (ul_count < 64 && t < 400) begin
            tick();
            ul_ready = ~ul_ready;
            t++;
        end
        if (ul_count < 64) fail("unload_drain");
        ul_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("unload_handshakes", ul_count, 64);
        check("unload_left", q_ul.size(), 0);
        check("unload_ul_valid", ul_valid, 1'b0);
        check("unload_bbusy", bridge_busy, 1'b0);
        tick();
        ul_ready = 1'b0;

        // Reset after 10 load bytes, then a fresh full LOAD.
        mon_load = 1'b1;
        busy = 1'b0;
        send_cmd(8'h04);
        send_loads(8'h20, 10);
        reset = 1'b1;
        #2;
        check_all_zero("rst_fill");
        tick();
        reset = 1'b0;
        q_load.delete();
        tick();
        @(negedge clk);
        check("rst_idle_ready", cmd_ready, 1'b1);
        tick();
        send_cmd(8'h04);
        send_loads(8'h40, 64);
        t = 0;
        @(negedge clk);
        while (q_load.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reload_stream_left", q_load.size(), 0);
        tick();
        wait_idle("reload_idle");
        mon_load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
